// File: rtl/noc_packet_framer_pkg.sv
// Shared definitions for the NoC packet framer: header field offsets,
// record flag positions, record layout and FSM state encoding.
package noc_packet_framer_pkg;

  // Header field positions inside a flit
  localparam int NOC_HDR_CHIPID_MSB = 63;
  localparam int NOC_HDR_CHIPID_LSB = 50;
  localparam int NOC_HDR_X_MSB      = 49;
  localparam int NOC_HDR_X_LSB      = 42;
  localparam int NOC_HDR_Y_MSB      = 41;
  localparam int NOC_HDR_Y_LSB      = 34;
  localparam int NOC_HDR_LEN_MSB    = 29;
  localparam int NOC_HDR_LEN_LSB    = 22;
  localparam int NOC_HDR_TYPE_MSB   = 21;
  localparam int NOC_HDR_TYPE_LSB   = 14;

  // Record flag bit positions; bits [7:3] are reserved and always zero
  localparam int NPF_FLAG_BOUND_ERR = 0;
  localparam int NPF_FLAG_TIMEOUT   = 1;
  localparam int NPF_FLAG_ZERO_LEN  = 2;

  localparam int NPF_REC_W = 40;

  typedef enum logic {
    NPF_IDLE = 1'b0,
    NPF_BODY = 1'b1
  } npf_state_e;

  typedef struct packed {
    logic [7:0] flags;
    logic [7:0] len;
    logic [7:0] typ;
    logic [7:0] y;
    logic [7:0] x;
  } npf_rec_t;

  function automatic logic [7:0] npf_flags(input logic bound_err, input logic timeout,
                                           input logic zero_len);
    logic [7:0] f;
    f = '0;
    f[NPF_FLAG_BOUND_ERR] = bound_err;
    f[NPF_FLAG_TIMEOUT]   = timeout;
    f[NPF_FLAG_ZERO_LEN]  = zero_len;
    return f;
  endfunction

endpackage

// File: rtl/noc_pkt_rec_fifo.sv
// Synchronous record FIFO with a registered head entry. A push while full
// is refused (reported on drop) unless a pop frees the slot the same cycle.
module noc_pkt_rec_fifo
  import noc_packet_framer_pkg::*;
#(
  parameter int DATA_W = NPF_REC_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic              drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_nxt;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              do_push;
  logic              do_pop;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign drop       = push && full && !do_pop;
  assign rd_nxt     = rd_ptr + AW'(1);
  assign head_valid = !empty;

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head register: next entry after a pop, or the incoming record when it
  // lands in an empty (or just emptied) FIFO; otherwise it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_data <= '0;
    end else if (do_pop) begin
      if (count > (AW+1)'(1)) head_data <= mem[rd_nxt];
      else if (do_push)       head_data <= push_data;
    end else if (do_push && empty) begin
      head_data <= push_data;
    end
  end

endmodule

// File: rtl/noc_packet_framer.sv
// Passive tap on one router output port: frames flits into packets using
// the header length, and queues one summary record per packet for the
// network monitor. Never back-pressures the NoC.
module noc_packet_framer
  import noc_packet_framer_pkg::*;
#(
  parameter int FLIT_W      = 64,
  parameter int X_TILES     = 1,
  parameter int Y_TILES     = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flit_valid,
  input  logic [FLIT_W-1:0]    flit_data,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [NPF_REC_W-1:0] rec_data,
  output logic [15:0]          drop_cnt,
  output logic                 overflow
);

  localparam int              CHIP_W   = NOC_HDR_CHIPID_MSB - NOC_HDR_CHIPID_LSB + 1;
  localparam int              GAP_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only on-chip destinations (chipid 0) are checked against the mesh size
  function automatic logic bound_err(input logic [CHIP_W-1:0] chipid,
                                     input logic [7:0] x, input logic [7:0] y);
    return (chipid == '0) &&
           (({24'd0, x} >= 32'(X_TILES)) || ({24'd0, y} >= 32'(Y_TILES)));
  endfunction

  npf_state_e         state;
  logic [7:0]         remaining;
  logic [GAP_W-1:0]   gap;

  logic [CHIP_W-1:0]  hdr_chipid;
  logic [7:0]         hdr_x, hdr_y, hdr_len, hdr_type;
  logic               hdr_bound;

  logic [7:0]         hdr_x_p0, hdr_y_p0, hdr_len_p0, hdr_type_p0;
  logic               hdr_bound_p0;

  logic               push;
  npf_rec_t           push_rec;
  logic               fifo_drop;
  logic               unused_flit_bits;

  assign hdr_chipid = flit_data[NOC_HDR_CHIPID_MSB:NOC_HDR_CHIPID_LSB];
  assign hdr_x      = flit_data[NOC_HDR_X_MSB:NOC_HDR_X_LSB];
  assign hdr_y      = flit_data[NOC_HDR_Y_MSB:NOC_HDR_Y_LSB];
  assign hdr_len    = flit_data[NOC_HDR_LEN_MSB:NOC_HDR_LEN_LSB];
  assign hdr_type   = flit_data[NOC_HDR_TYPE_MSB:NOC_HDR_TYPE_LSB];
  assign hdr_bound  = bound_err(hdr_chipid, hdr_x, hdr_y);
  assign unused_flit_bits = ^{flit_data[NOC_HDR_Y_LSB-1:NOC_HDR_LEN_MSB+1],
                              flit_data[NOC_HDR_TYPE_LSB-1:0]};

  // Record push decision: on the edge that consumes the last flit, on a
  // zero-length header, or when the body gap reaches the timeout.
  always_comb begin
    push     = 1'b0;
    push_rec = '0;
    case (state)
      NPF_IDLE: begin
        if (flit_valid && (hdr_len == 8'd0)) begin
          push     = 1'b1;
          push_rec = '{flags: npf_flags(hdr_bound, 1'b0, 1'b1),
                       len: hdr_len, typ: hdr_type, y: hdr_y, x: hdr_x};
        end
      end
      NPF_BODY: begin
        if (flit_valid) begin
          if (remaining == 8'd1) begin
            push     = 1'b1;
            push_rec = '{flags: npf_flags(hdr_bound_p0, 1'b0, 1'b0),
                         len: hdr_len_p0, typ: hdr_type_p0, y: hdr_y_p0, x: hdr_x_p0};
          end
        end else if (gap == GAP_LAST) begin
          push     = 1'b1;
          push_rec = '{flags: npf_flags(hdr_bound_p0, 1'b1, 1'b0),
                       len: hdr_len_p0, typ: hdr_type_p0, y: hdr_y_p0, x: hdr_x_p0};
        end
      end
      default: ;
    endcase
  end

  // Framer FSM with remaining-flit and idle-gap counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= NPF_IDLE;
      remaining <= '0;
      gap       <= '0;
    end else begin
      case (state)
        NPF_IDLE: begin
          if (flit_valid && (hdr_len != 8'd0)) begin
            state     <= NPF_BODY;
            remaining <= hdr_len;
            gap       <= '0;
          end
        end
        NPF_BODY: begin
          if (flit_valid) begin
            remaining <= remaining - 8'd1;
            gap       <= '0;
            if (remaining == 8'd1) state <= NPF_IDLE;
          end else if (gap == GAP_LAST) begin
            state     <= NPF_IDLE;
            remaining <= '0;
            gap       <= '0;
          end else begin
            gap <= gap + GAP_W'(1);
          end
        end
        default: state <= NPF_IDLE;
      endcase
    end
  end

  // Header field capture for packets that carry body flits
  always_ff @(posedge clk) begin
    if ((state == NPF_IDLE) && flit_valid) begin
      hdr_x_p0     <= hdr_x;
      hdr_y_p0     <= hdr_y;
      hdr_len_p0   <= hdr_len;
      hdr_type_p0  <= hdr_type;
      hdr_bound_p0 <= hdr_bound;
    end
  end

  // Saturating drop counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      drop_cnt <= sat_inc16(drop_cnt);
      overflow <= 1'b1;
    end
  end

  noc_pkt_rec_fifo #(
    .DATA_W (NPF_REC_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_rec),
    .pop        (rec_ready),
    .head_valid (rec_valid),
    .head_data  (rec_data),
    .drop       (fifo_drop)
  );

endmodule

// File: tb/tb_noc_packet_framer.sv
// Bench for noc_packet_framer: packet-level stimulus with a queue-based
// record model; each scenario task checks its own observations.
module tb_noc_packet_framer;

  localparam int X_T   = 1;
  localparam int Y_T   = 1;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flit_valid = 1'b0;
  logic [63:0] flit_data = '0;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [39:0] rec_data;
  logic [15:0] drop_cnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [39:0] mq[$];
  logic [15:0] m_drop = '0;
  logic        m_ovf = 1'b0;
  logic        rdy_rand = 1'b0;

  always #5 clk = ~clk;

  noc_packet_framer #(
    .FLIT_W(64), .X_TILES(X_T), .Y_TILES(Y_T), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .flit_valid(flit_valid), .flit_data(flit_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] mk_hdr(input logic [13:0] c, input logic [7:0] x,
                                         input logic [7:0] y, input logic [7:0] len,
                                         input logic [7:0] typ);
    logic [63:0] h;
    h = rand64();
    h[63:50] = c; h[49:42] = x; h[41:34] = y; h[29:22] = len; h[21:14] = typ;
    return h;
  endfunction

  function automatic logic [39:0] exp_rec(input logic [13:0] c, input logic [7:0] x,
                                          input logic [7:0] y, input logic [7:0] typ,
                                          input logic [7:0] len, input logic tmo);
    logic [7:0] f;
    f = '0;
    f[0] = (c == 14'd0) && ((int'(x) >= X_T) || (int'(y) >= Y_T));
    f[1] = tmo;
    f[2] = (len == 8'd0);
    return {f, len, typ, y, x};
  endfunction

  // One clock: drive a flit, then advance the record model
  task automatic step(input logic v, input logic [63:0] d, input logic exp_push,
                      input logic [39:0] r);
    logic popped;
    flit_valid = v;
    flit_data  = d;
    if (rdy_rand) rec_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    popped = rec_ready && (mq.size() > 0);
    if (popped) void'(mq.pop_front());
    if (exp_push) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        m_ovf = 1'b1;
      end
    end
    #1;
    flit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rand64(), 1'b0, '0);
  endtask

  task automatic send_pkt(input logic [13:0] c, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] typ, input logic [7:0] len, input int maxgap);
    logic [39:0] r;
    int g;
    r = exp_rec(c, x, y, typ, len, 1'b0);
    step(1'b1, mk_hdr(c, x, y, len, typ), len == 8'd0, r);
    for (int i = 0; i < int'(len); i++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      idle(g);
      step(1'b1, rand64(), i == int'(len) - 1, r);
    end
  endtask

  task automatic send_trunc(input logic [13:0] c, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] typ, input logic [7:0] len, input int nbody);
    logic [39:0] r;
    r = exp_rec(c, x, y, typ, len, 1'b1);
    step(1'b1, mk_hdr(c, x, y, len, typ), 1'b0, '0);
    for (int i = 0; i < nbody; i++) step(1'b1, rand64(), 1'b0, '0);
    for (int i = 0; i < TMO; i++) step(1'b0, rand64(), i == TMO - 1, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flit_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_drop = '0;
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rec_valid); end
    checks++; if (rec_data !== 40'd0) begin errors++; $display("FAIL reset_data got %h exp 0", rec_data); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_basic();
    logic [7:0] typ;
    typ = 8'($urandom);
    rec_ready = 1'b0;
    step(1'b1, mk_hdr(14'd0, 8'd0, 8'd0, 8'd2, typ), 1'b0, '0);
    step(1'b1, rand64(), 1'b0, '0);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %b exp 0", rec_valid); end
    step(1'b1, rand64(), 1'b1, {8'h00, 8'd2, typ, 8'd0, 8'd0});
    checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", rec_valid); end
    checks++; if (rec_data !== {8'h00, 8'd2, typ, 8'd0, 8'd0}) begin
      errors++; $display("FAIL basic_data got %h exp %h", rec_data, {8'h00, 8'd2, typ, 8'd0, 8'd0}); end
    rec_ready = 1'b1;
    idle(1);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", rec_valid); end
    rec_ready = 1'b0;
  endtask

  task automatic test_zero_len_burst();
    logic [39:0] r;
    rec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r = {8'h04, 8'd0, 8'(8'h30 + i), 8'd0, 8'(i + 5)};
      step(1'b1, mk_hdr(14'd1, 8'(i + 5), 8'd0, 8'd0, 8'(8'h30 + i)), 1'b1, r);
      checks++; if (rec_valid !== 1'b1 || rec_data !== r) begin
        errors++; $display("FAIL zlen_%0d got %b/%h exp 1/%h", i, rec_valid, rec_data, r); end
    end
    idle(1);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL zlen_drain got %b exp 0", rec_valid); end
    rec_ready = 1'b0;
  endtask

  task automatic test_bound();
    logic [13:0] cs [3] = '{14'd0, 14'd1, 14'd0};
    logic [7:0]  xs [3] = '{8'd1, 8'd1, 8'd0};
    logic [7:0]  ys [3] = '{8'd0, 8'd0, 8'd1};
    logic [7:0]  fe [3] = '{8'h01, 8'h00, 8'h01};
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_pkt(cs[i], xs[i], ys[i], 8'hA5, 8'd1, 0);
      checks++; if (rec_valid !== 1'b1 || rec_data[39:32] !== fe[i]) begin
        errors++; $display("FAIL bound_%0d got %b/%h exp 1/%h", i, rec_valid, rec_data[39:32], fe[i]); end
      rec_ready = 1'b1; idle(1); rec_ready = 1'b0;
    end
  endtask

  task automatic test_timeout();
    rec_ready = 1'b0;
    step(1'b1, mk_hdr(14'd0, 8'd0, 8'd0, 8'd3, 8'h11), 1'b0, '0);
    step(1'b1, rand64(), 1'b0, '0);
    idle(TMO - 1);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL tmo_early got %b exp 0", rec_valid); end
    step(1'b0, rand64(), 1'b1, {8'h02, 8'd3, 8'h11, 8'd0, 8'd0});
    checks++; if (rec_valid !== 1'b1 || rec_data !== {8'h02, 8'd3, 8'h11, 8'd0, 8'd0}) begin
      errors++; $display("FAIL tmo_rec got %b/%h exp 1/%h", rec_valid, rec_data, {8'h02, 8'd3, 8'h11, 8'd0, 8'd0}); end
    rec_ready = 1'b1; idle(1); rec_ready = 1'b0;
    // longest legal gap between body flits must not time out
    step(1'b1, mk_hdr(14'd0, 8'd0, 8'd0, 8'd2, 8'h22), 1'b0, '0);
    step(1'b1, rand64(), 1'b0, '0);
    idle(TMO - 1);
    step(1'b1, rand64(), 1'b1, {8'h00, 8'd2, 8'h22, 8'd0, 8'd0});
    checks++; if (rec_valid !== 1'b1 || rec_data !== {8'h00, 8'd2, 8'h22, 8'd0, 8'd0}) begin
      errors++; $display("FAIL tmo_gap got %b/%h exp 1/%h", rec_valid, rec_data, {8'h00, 8'd2, 8'h22, 8'd0, 8'd0}); end
    rec_ready = 1'b1; idle(1); rec_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    rec_ready = 1'b0;
    send_pkt(14'd0, 8'd0, 8'd0, 8'h41, 8'd1, 0);
    send_pkt(14'd0, 8'd0, 8'd0, 8'h42, 8'd2, 0);
    checks++; if (rec_data !== {8'h00, 8'd1, 8'h41, 8'd0, 8'd0}) begin
      errors++; $display("FAIL b2b_first got %h exp %h", rec_data, {8'h00, 8'd1, 8'h41, 8'd0, 8'd0}); end
    rec_ready = 1'b1; idle(1);
    checks++; if (rec_valid !== 1'b1 || rec_data !== {8'h00, 8'd2, 8'h42, 8'd0, 8'd0}) begin
      errors++; $display("FAIL b2b_second got %b/%h exp 1/%h", rec_valid, rec_data, {8'h00, 8'd2, 8'h42, 8'd0, 8'd0}); end
    idle(1); rec_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [39:0] r [7];
    rec_ready = 1'b0;
    for (int i = 0; i < 7; i++) r[i] = {8'h04, 8'd0, 8'(8'h60 + i), 8'd0, 8'(i)};
    for (int i = 0; i < 6; i++)
      step(1'b1, mk_hdr(14'd3, 8'(i), 8'd0, 8'd0, 8'(8'h60 + i)), 1'b1, r[i]);
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (rec_data !== r[0]) begin errors++; $display("FAIL ovf_head got %h exp %h", rec_data, r[0]); end
    rec_ready = 1'b1;
    step(1'b1, mk_hdr(14'd3, 8'd6, 8'd0, 8'd0, 8'h66), 1'b1, r[6]);
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_pushpop got %0d exp 2", drop_cnt); end
    checks++; if (rec_data !== r[1]) begin errors++; $display("FAIL ovf_head1 got %h exp %h", rec_data, r[1]); end
    idle(1);
    checks++; if (rec_data !== r[2]) begin errors++; $display("FAIL ovf_head2 got %h exp %h", rec_data, r[2]); end
    idle(1);
    checks++; if (rec_data !== r[3]) begin errors++; $display("FAIL ovf_head3 got %h exp %h", rec_data, r[3]); end
    idle(1);
    checks++; if (rec_data !== r[6]) begin errors++; $display("FAIL ovf_head6 got %h exp %h", rec_data, r[6]); end
    idle(1);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", rec_valid); end
    rec_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rec_ready = 1'b0;
    step(1'b1, mk_hdr(14'd0, 8'd0, 8'd0, 8'd5, 8'h77), 1'b0, '0);
    step(1'b1, rand64(), 1'b0, '0);
    step(1'b1, rand64(), 1'b0, '0);
    do_reset();
    checks++; if (rec_valid !== 1'b0 || drop_cnt !== 16'd0 || overflow !== 1'b0 || rec_data !== 40'd0) begin
      errors++; $display("FAIL rmid_state got %b/%0d/%b/%h exp 0/0/0/0", rec_valid, drop_cnt, overflow, rec_data); end
    send_pkt(14'd0, 8'd0, 8'd0, 8'h78, 8'd1, 0);
    checks++; if (rec_valid !== 1'b1 || rec_data !== {8'h00, 8'd1, 8'h78, 8'd0, 8'd0}) begin
      errors++; $display("FAIL rmid_rec got %b/%h exp 1/%h", rec_valid, rec_data, {8'h00, 8'd1, 8'h78, 8'd0, 8'd0}); end
    rec_ready = 1'b1; idle(1);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL rmid_single got %b exp 0", rec_valid); end
    rec_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [13:0] c;
    logic [7:0]  len;
    rdy_rand = 1'b1;
    for (int p = 0; p < 150; p++) begin
      c   = ($urandom_range(0, 1) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
      len = 8'($urandom_range(0, 5));
      if (len != 8'd0 && $urandom_range(0, 7) == 0)
        send_trunc(c, 8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 8'($urandom), len,
                   int'($urandom_range(0, int'(len) - 1)));
      else
        send_pkt(c, 8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 8'($urandom), len, 3);
      checks++; if (rec_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rnd_valid_%0d got %b exp %b", p, rec_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if (rec_data !== mq[0]) begin
          errors++; $display("FAIL rnd_data_%0d got %h exp %h", p, rec_data, mq[0]); end
      end
      checks++; if (drop_cnt !== m_drop || overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_drop_%0d got %0d/%b exp %0d/%b", p, drop_cnt, overflow, m_drop, m_ovf); end
    end
    rdy_rand = 1'b0;
    rec_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1 && mq.size() > 0; i++) begin
      checks++; if (rec_data !== mq[0]) begin
        errors++; $display("FAIL rnd_drain_%0d got %h exp %h", i, rec_data, mq[0]); end
      idle(1);
    end
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL rnd_empty got %b exp 0", rec_valid); end
    rec_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len_burst();
    test_bound();
    test_timeout();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
